round_control_fsm: RTL and testbench
====================================

ROUND_CONTROL_FSM -- requirements
Module: round_control_fsm

Interface
REQ-001 SHALL have parameter COUNTDOWN_SEC, default 5, countdown length in seconds (>=1).
REQ-002 SHALL have parameter GAME_SEC, default 30, per-round play length in seconds (>=1).
REQ-003 SHALL have parameter NUM_ROUNDS, default 3, rounds per game (>=1).
REQ-004 SHALL have parameter SCORE_W, default 8, score width; parameter LEVEL_W, default 2, difficulty width.
REQ-005 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: tick_1hz  in  1  one-cycle pulse per second; btn_start, btn_pause, btn_clear_hs, btn_level  in  1 each  one-cycle pulses.
REQ-007 SHALL have ports: level_in  in  LEVEL_W  requested base level; score  in  SCORE_W  current round score from scorer.
REQ-008 SHALL have ports: enable_score, clear_score, enable_mole_ctrl  out  1; level  out  LEVEL_W  active level; round_num  out  clog2(NUM_ROUNDS+1)  current round, 1-based.
REQ-009 SHALL have ports: state_code  out  3  current state; display_value  out  SCORE_W; total_score, high_score  out  SCORE_W.

Function
REQ-010 States: IDLE, COUNTDOWN, PLAYING, PAUSED, ROUND_END, GAME_OVER.
REQ-011 Internal seconds counter sec, width clog2(max(COUNTDOWN_SEC,GAME_SEC)+1), cleared on every state entry, incremented only on tick_1hz in COUNTDOWN/PLAYING.
REQ-012 Input priority each cycle: btn_start > btn_pause > tick_1hz; a lower-priority event in the same cycle is discarded.
REQ-013 btn_start in any state: go to COUNTDOWN, sec=0, round_num=1, total_score=0 (full restart, including restart during COUNTDOWN).
REQ-014 COUNTDOWN: tick with sec==COUNTDOWN_SEC-1 -> PLAYING; display_value=COUNTDOWN_SEC-sec, zero-extended.
REQ-015 PLAYING: tick with sec==GAME_SEC-1 -> ROUND_END; btn_pause -> PAUSED (sec held); display_value=score.
REQ-016 PAUSED: ticks ignored, sec held; btn_pause -> PLAYING with sec unchanged; display_value=score.
REQ-017 ROUND_END lasts exactly one cycle: total_score += score, saturating at 2^SCORE_W-1.
REQ-018 ROUND_END exit: round_num==NUM_ROUNDS -> GAME_OVER; else round_num+1 and -> COUNTDOWN.
REQ-019 On entry to GAME_OVER, high_score SHALL load the final total_score if strictly greater.
REQ-020 GAME_OVER: display_value=total_score; holds until btn_start. IDLE: display_value=0.
REQ-021 btn_level SHALL load level_in into base level only in IDLE/GAME_OVER; ignored elsewhere.
REQ-022 level = min(base + round_num-1, 2^LEVEL_W-1) (saturating escalation per round).
REQ-023 btn_clear_hs SHALL zero high_score only in IDLE/GAME_OVER; ignored elsewhere.
REQ-024 enable_score, enable_mole_ctrl =1 only in PLAYING; clear_score =1 in IDLE and COUNTDOWN.
REQ-025 All outputs SHALL be decoded from registers only; no combinational input-to-output path; state change visible on outputs the cycle after the causing event.

Reset
REQ-026 On rst_n low: state=IDLE, sec=0, round_num=1, base level=0, total_score=0, high_score=0.
REQ-027 Reset outputs: enables=0, clear_score=1, level=0, display_value=0, state_code=IDLE.
REQ-028 Reset mid-game SHALL abort immediately, including high_score clearing; no partial round accumulation.

Structure
REQ-029 State encoding (3-bit) and default timing constants SHALL live in shared package game_pkg.
REQ-030 Seconds counter SHALL be a sub-module sec_counter (clear, enable, tick inputs; count output).
REQ-031 Target size 120-400 lines RTL; single clock domain.

Verification (bench params COUNTDOWN_SEC=2, GAME_SEC=3, NUM_ROUNDS=2, SCORE_W=8)
REQ-032 Start, 2 ticks -> PLAYING; display 2,1 during countdown; enable_score=1 after second tick.
REQ-033 Two rounds with score 100 then 200 -> total_score=255 (saturated), high_score=255, GAME_OVER.
REQ-034 Pause after 1 tick, 5 ticks while PAUSED, resume, 2 ticks -> ROUND_END exactly then; sec held at 1 while paused.
REQ-035 btn_start and final tick same cycle in PLAYING -> COUNTDOWN round 1, total 0, no ROUND_END.
REQ-036 Base level 3 loaded in IDLE -> level 3 both rounds; base 1 -> level 1 then 2; btn_level during PLAYING ignored.
REQ-037 Second game with total 50 after high_score 255 -> high_score stays 255; btn_clear_hs in GAME_OVER -> 0; rst_n mid-PLAYING -> REQ-027 values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared state encoding and default timing for the whack-a-mole game.
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_PLAYING   = 3'd2,
      ST_PAUSED    = 3'd3,
      ST_ROUND_END = 3'd4,
      ST_GAME_OVER = 3'd5
   } state_t;

   localparam int DEF_COUNTDOWN_SEC = 5;
   localparam int DEF_GAME_SEC      = 30;
   localparam int DEF_NUM_ROUNDS    = 3;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sec_counter.sv
// Seconds counter: synchronous clear wins over a counted tick.
module sec_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         enable,
   input  logic         tick,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && tick)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/round_control_fsm.sv
// Round/game sequencer: countdown, play, pause, per-round scoring, high score.
module round_control_fsm
   import game_pkg::*;
#(
   parameter int COUNTDOWN_SEC = DEF_COUNTDOWN_SEC,
   parameter int GAME_SEC      = DEF_GAME_SEC,
   parameter int NUM_ROUNDS    = DEF_NUM_ROUNDS,
   parameter int SCORE_W       = 8,
   parameter int LEVEL_W       = 2,
   localparam int RND_W        = $clog2(NUM_ROUNDS + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick_1hz,
   input  logic               btn_start,
   input  logic               btn_pause,
   input  logic               btn_clear_hs,
   input  logic               btn_level,
   input  logic [LEVEL_W-1:0] level_in,
   input  logic [SCORE_W-1:0] score,
   output logic               enable_score,
   output logic               clear_score,
   output logic               enable_mole_ctrl,
   output logic [LEVEL_W-1:0] level,
   output logic [RND_W-1:0]   round_num,
   output logic [2:0]         state_code,
   output logic [SCORE_W-1:0] display_value,
   output logic [SCORE_W-1:0] total_score,
   output logic [SCORE_W-1:0] high_score
);

   localparam int SEC_W   = $clog2(max_i(COUNTDOWN_SEC, GAME_SEC) + 1);
   localparam int LVL_MAX = (1 << LEVEL_W) - 1;
   localparam logic [SEC_W-1:0]   CD_LAST = SEC_W'(COUNTDOWN_SEC - 1);
   localparam logic [SEC_W-1:0]   GM_LAST = SEC_W'(GAME_SEC - 1);
   localparam logic [SCORE_W-1:0] CD_VAL  = SCORE_W'(COUNTDOWN_SEC);
   localparam logic [RND_W-1:0]   RND_LAST = RND_W'(NUM_ROUNDS);

   state_t             state;
   logic [SEC_W-1:0]   sec;
   logic [RND_W-1:0]   round_q;
   logic [LEVEL_W-1:0] base_lvl;
   logic [SCORE_W-1:0] total_q;
   logic [SCORE_W-1:0] high_q;
   logic [SCORE_W-1:0] score_q;

   logic               pause_ev;
   logic               tick_ev;
   logic               cd_done;
   logic               gm_done;
   logic               sec_clr;
   logic               sec_en;
   logic               idle_like;
   logic [SCORE_W:0]   sum;
   logic [SCORE_W-1:0] total_nxt;
   int                 lvl_sum;

   // start beats pause beats tick; losers are dropped
   always_comb begin
      pause_ev  = !btn_start && btn_pause;
      tick_ev   = !btn_start && !btn_pause && tick_1hz;
      cd_done   = (state == ST_COUNTDOWN) && tick_ev && (sec == CD_LAST);
      gm_done   = (state == ST_PLAYING) && tick_ev && (sec == GM_LAST);
      sec_en    = (state == ST_COUNTDOWN) || (state == ST_PLAYING);
      sec_clr   = btn_start || cd_done || gm_done ||
                  (state == ST_ROUND_END);
      idle_like = (state == ST_IDLE) || (state == ST_GAME_OVER);
      sum       = {1'b0, total_q} + {1'b0, score};
      total_nxt = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
   end

   sec_counter #(
      .W(SEC_W)
   ) u_sec (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (sec_clr),
      .enable(sec_en),
      .tick  (tick_ev),
      .count (sec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         round_q  <= RND_W'(1);
         base_lvl <= '0;
         total_q  <= '0;
         high_q   <= '0;
         score_q  <= '0;
      end else begin
         score_q <= score;
         if (idle_like && btn_level)
            base_lvl <= level_in;
         if (idle_like && btn_clear_hs)
            high_q <= '0;
         if (btn_start) begin
            state   <= ST_COUNTDOWN;
            round_q <= RND_W'(1);
            total_q <= '0;
         end else begin
            unique case (state)
               ST_COUNTDOWN: if (cd_done) state <= ST_PLAYING;
               ST_PLAYING: begin
                  if (pause_ev)
                     state <= ST_PAUSED;
                  else if (gm_done)
                     state <= ST_ROUND_END;
               end
               ST_PAUSED: if (pause_ev) state <= ST_PLAYING;
               ST_ROUND_END: begin
                  total_q <= total_nxt;
                  if (round_q == RND_LAST) begin
                     state <= ST_GAME_OVER;
                     if (total_nxt > high_q)
                        high_q <= total_nxt;
                  end else begin
                     round_q <= round_q + 1'b1;
                     state   <= ST_COUNTDOWN;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_code       = state;
      enable_score     = (state == ST_PLAYING);
      enable_mole_ctrl = (state == ST_PLAYING);
      clear_score      = (state == ST_IDLE) || (state == ST_COUNTDOWN);
      round_num        = round_q;
      total_score      = total_q;
      high_score       = high_q;
      lvl_sum          = int'(base_lvl) + int'(round_q) - 1;
      level            = (lvl_sum > LVL_MAX) ? '1 : LEVEL_W'(lvl_sum);
      unique case (state)
         ST_IDLE:      display_value = '0;
         ST_COUNTDOWN: display_value = CD_VAL - SCORE_W'(sec);
         ST_PLAYING,
         ST_PAUSED:    display_value = score_q;
         default:      display_value = total_q;
      endcase
   end

endmodule

// File: tb/tb_round_control_fsm.sv
// Scoreboard bench for round_control_fsm with short timing parameters.
module tb_round_control_fsm;

   localparam int F_STATE = 0, F_DISP = 1, F_TOT = 2, F_HS = 3;
   localparam int F_RND = 4, F_LVL = 5, F_ENS = 6, F_CLR = 7, F_ENM = 8;

   typedef struct {
      int    cyc;
      string name;
      int    fld;
      int    val;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_pause = 1'b0;
   logic       btn_clear_hs = 1'b0;
   logic       btn_level = 1'b0;
   logic [1:0] level_in = '0;
   logic [7:0] score = '0;
   logic       enable_score, clear_score, enable_mole_ctrl;
   logic [1:0] level;
   logic [1:0] round_num;
   logic [2:0] state_code;
   logic [7:0] display_value, total_score, high_score;

   exp_t sb[$];
   exp_t e;
   int   act;
   int   cyc = 0;
   int   vectors = 0;
   int   errors = 0;

   round_control_fsm #(
      .COUNTDOWN_SEC(2),
      .GAME_SEC     (3),
      .NUM_ROUNDS   (2),
      .SCORE_W      (8),
      .LEVEL_W      (2)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .tick_1hz        (tick_1hz),
      .btn_start       (btn_start),
      .btn_pause       (btn_pause),
      .btn_clear_hs    (btn_clear_hs),
      .btn_level       (btn_level),
      .level_in        (level_in),
      .score           (score),
      .enable_score    (enable_score),
      .clear_score     (clear_score),
      .enable_mole_ctrl(enable_mole_ctrl),
      .level           (level),
      .round_num       (round_num),
      .state_code      (state_code),
      .display_value   (display_value),
      .total_score     (total_score),
      .high_score      (high_score)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int get(input int f);
      case (f)
         F_STATE: return int'(state_code);
         F_DISP:  return int'(display_value);
         F_TOT:   return int'(total_score);
         F_HS:    return int'(high_score);
         F_RND:   return int'(round_num);
         F_LVL:   return int'(level);
         F_ENS:   return int'(enable_score);
         F_CLR:   return int'(clear_score);
         F_ENM:   return int'(enable_mole_ctrl);
         default: return -1;
      endcase
   endfunction

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         act = get(e.fld);
         vectors++;
         if (e.cyc != cyc || act != e.val) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     e.name, act, e.val, cyc);
         end
      end
   end

   task automatic chk(input string name, input int f, input int v);
      sb.push_back('{cyc, name, f, v});
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      tick_1hz     = 1'b0;
      btn_start    = 1'b0;
      btn_pause    = 1'b0;
      btn_clear_hs = 1'b0;
      btn_level    = 1'b0;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         tick_1hz = 1'b1;
         cycle();
      end
   endtask

   // countdown (2) + play (3) + the single ROUND_END cycle
   task automatic play_round();
      tick_n(2);
      tick_n(3);
      cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      #1;
      chk("rst_state", F_STATE, 0);
      chk("rst_disp", F_DISP, 0);
      chk("rst_clr", F_CLR, 1);
      chk("rst_ens", F_ENS, 0);
      chk("rst_enm", F_ENM, 0);
      chk("rst_lvl", F_LVL, 0);
      chk("rst_tot", F_TOT, 0);
      chk("rst_hs", F_HS, 0);
      chk("rst_rnd", F_RND, 1);
      cycle();
      rst_n = 1'b1;
      cycle();

      // game 1: base level 3, scores 100 then 200
      level_in = 2'd3; btn_level = 1'b1; cycle();
      chk("idle_lvl3", F_LVL, 3);
      score = 8'd100; btn_start = 1'b1; cycle();
      chk("cd_state", F_STATE, 1);
      chk("cd_disp2", F_DISP, 2);
      chk("cd_clr", F_CLR, 1);
      chk("cd_rnd1", F_RND, 1);
      chk("g1r1_lvl", F_LVL, 3);
      chk("cd_ens0", F_ENS, 0);
      tick_n(1);
      chk("cd_disp1", F_DISP, 1);
      chk("cd_state1", F_STATE, 1);
      tick_n(1);
      chk("play_state", F_STATE, 2);
      chk("play_ens", F_ENS, 1);
      chk("play_enm", F_ENM, 1);
      chk("play_clr", F_CLR, 0);
      chk("play_disp", F_DISP, 100);
      tick_n(2);
      chk("play_hold", F_STATE, 2);
      tick_n(1);
      chk("round_end", F_STATE, 4);
      cycle();
      chk("r2_state", F_STATE, 1);
      chk("r2_rnd", F_RND, 2);
      chk("r1_total", F_TOT, 100);
      chk("g1r2_lvl_sat", F_LVL, 3);
      score = 8'd200;
      tick_n(2);
      chk("r2_disp200", F_DISP, 200);
      tick_n(3);
      chk("r2_end", F_STATE, 4);
      cycle();
      chk("go_state", F_STATE, 5);
      chk("go_tot_sat", F_TOT, 255);
      chk("go_hs", F_HS, 255);
      chk("go_disp", F_DISP, 255);
      chk("go_ens", F_ENS, 0);

      // game 2: base level 1, total 50 keeps high score
      level_in = 2'd1; btn_level = 1'b1; cycle();
      chk("go_lvl_r2", F_LVL, 2);
      score = 8'd25; btn_start = 1'b1; cycle();
      chk("g2_rnd1", F_RND, 1);
      chk("g2_lvl1", F_LVL, 1);
      chk("g2_tot0", F_TOT, 0);
      tick_n(2);
      level_in = 2'd3; btn_level = 1'b1; btn_clear_hs = 1'b1; cycle();
      chk("play_lvl_ign", F_LVL, 1);
      chk("play_clrhs_ign", F_HS, 255);
      tick_n(3);
      chk("g2_r1_end", F_STATE, 4);
      cycle();
      chk("g2_lvl2", F_LVL, 2);
      chk("g2_tot25", F_TOT, 25);
      play_round();
      chk("g2_go", F_STATE, 5);
      chk("g2_tot50", F_TOT, 50);
      chk("g2_hs_keep", F_HS, 255);
      btn_clear_hs = 1'b1; cycle();
      chk("hs_cleared", F_HS, 0);

      // game 3: pause with ticks held off, then restart on last tick
      score = 8'd10; btn_start = 1'b1; cycle();
      tick_n(2);
      chk("g3_play", F_STATE, 2);
      tick_n(1);
      btn_pause = 1'b1; cycle();
      chk("paused", F_STATE, 3);
      chk("paused_ens", F_ENS, 0);
      chk("paused_disp", F_DISP, 10);
      tick_n(5);
      chk("paused_hold", F_STATE, 3);
      btn_pause = 1'b1; cycle();
      chk("resumed", F_STATE, 2);
      chk("resumed_ens", F_ENS, 1);
      tick_n(1);
      chk("resume_sec2", F_STATE, 2);
      tick_n(1);
      chk("pause_end", F_STATE, 4);
      cycle();
      chk("g3_tot10", F_TOT, 10);
      tick_n(4);
      chk("g3_r2_play", F_STATE, 2);
      btn_start = 1'b1; tick_1hz = 1'b1; cycle();
      chk("rs_state", F_STATE, 1);
      chk("rs_rnd", F_RND, 1);
      chk("rs_tot", F_TOT, 0);
      chk("rs_disp", F_DISP, 2);
      cycle();
      chk("rs_no_end", F_STATE, 1);

      // finish game 3, then reset in the middle of game 4
      play_round();
      play_round();
      chk("g3_go", F_STATE, 5);
      chk("g3_hs20", F_HS, 20);
      btn_start = 1'b1; cycle();
      tick_n(3);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_state", F_STATE, 0);
      chk("mid_rst_hs", F_HS, 0);
      chk("mid_rst_tot", F_TOT, 0);
      chk("mid_rst_lvl", F_LVL, 0);
      chk("mid_rst_ens", F_ENS, 0);
      chk("mid_rst_clr", F_CLR, 1);
      chk("mid_rst_disp", F_DISP, 0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      cycle();
      chk("post_rst_idle", F_STATE, 0);
      cycle();
      cycle();
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
